// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller:
// opcodes, FSM state encoding and register-index width.
package ctrl_pkg;

  localparam int unsigned REG_W = 2;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b1010;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MUL_BUSY = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline stall/flush sequencer: load-use stalls, EX branch redirects and
// multi-cycle multiply occupancy, plus saturating debug counters.
module hazard_flush_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [3:0]  MUL_OP      = ALU_MUL,
  parameter int unsigned MUL_LAT     = 3,
  parameter int unsigned FLUSH_EXTRA = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [3:0]       ex_alu_op,
  input  logic             ex_branch_taken,
  input  logic [7:0]       ex_branch_target,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_redirect,
  output logic [7:0]       pc_target,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [3:0] MUL_CNT = 4'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [3:0] BR_CNT  = 4'((FLUSH_EXTRA > 0) ? FLUSH_EXTRA - 1 : 0);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  logic       redirect_evt;
  logic       stall_evt;

  assign load_use = ex_mem_read & ex_reg_write &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = ex_branch_target;
    redirect_evt = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          pc_redirect  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          redirect_evt = 1'b1;
          if (FLUSH_EXTRA > 0) begin
            state_d = BR_FLUSH;
            cnt_d   = BR_CNT;
          end
        end else if ((ex_alu_op == MUL_OP) && (MUL_LAT > 1)) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          cnt_d        = MUL_CNT;
          state_d      = MUL_BUSY;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      BR_FLUSH: begin
        if_id_flush = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MUL_BUSY: begin
        // cnt==0 is the cycle the multiply result leaves EX, so outputs stay default.
        if (cnt_q != '0) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          cnt_d        = cnt_q - 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      pc_redirect  = 1'b0;
      redirect_evt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_evt = ~pc_write & ~rst;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_evt),
    .count_o (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (redirect_evt),
    .count_o (flush_events)
  );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed self-checking bench for hazard_flush_ctrl (default instance plus a MUL_LAT=4 instance).
module tb_hazard_flush_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read, ex_branch_taken;
  logic [3:0]  ex_alu_op;
  logic [7:0]  ex_branch_target;

  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, pc_redirect;
  logic [7:0]  pc_target;
  logic [15:0] stall_cycles, flush_events;

  logic        pc_write4, if_id_write4, if_id_flush4, id_ex_write4, id_ex_flush4, ex_mem_flush4, pc_redirect4;
  logic [7:0]  pc_target4;
  logic [15:0] stall_cycles4, flush_events4;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, pc_redirect
  localparam logic [6:0] C_RESET = 7'b0010110;
  localparam logic [6:0] C_DEF   = 7'b1101000;
  localparam logic [6:0] C_BR    = 7'b1111101;
  localparam logic [6:0] C_BRF   = 7'b1111000;
  localparam logic [6:0] C_MUL   = 7'b0000010;
  localparam logic [6:0] C_LU    = 7'b0001100;

  logic [6:0] ctl, ctl4;
  assign ctl  = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, pc_redirect};
  assign ctl4 = {pc_write4, if_id_write4, if_id_flush4, id_ex_write4, id_ex_flush4, ex_mem_flush4, pc_redirect4};

  always #5 clk = ~clk;

  hazard_flush_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  hazard_flush_ctrl #(.MUL_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .pc_write(pc_write4), .if_id_write(if_id_write4),
    .if_id_flush(if_id_flush4), .id_ex_write(id_ex_write4), .id_ex_flush(id_ex_flush4),
    .ex_mem_flush(ex_mem_flush4), .pc_redirect(pc_redirect4), .pc_target(pc_target4),
    .stall_cycles(stall_cycles4), .flush_events(flush_events4)
  );

  always @(posedge clk)
    if (!rst) assert (!(ex_branch_taken && ex_alu_op == ALU_MUL))
      else $error("illegal branch+multiply in EX");

  task automatic clear_inputs;
    id_rs = 2'd0; id_rt = 2'd0; ex_rd = 2'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_alu_op = ALU_ADD; ex_branch_taken = 1'b0; ex_branch_target = 8'h00;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_load_use(input logic [1:0] rd, input logic [1:0] rs, input logic urs,
                              input logic [1:0] rt, input logic urt);
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (ctl !== C_RESET) $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET); else pass_cnt++;
    total_cnt++;
    if (stall_cycles !== 16'd0 || flush_events !== 16'd0)
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_events); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    total_cnt++;
    if (ctl !== C_DEF) $display("FAIL reset_release got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
  endtask

  task automatic test_load_use;
    do_reset();
    set_load_use(2'd2, 2'd2, 1'b1, 2'd1, 1'b1);
    #1;
    total_cnt++;
    if (ctl !== C_LU) $display("FAIL lu_rs_stall got=%b exp=%b", ctl, C_LU); else pass_cnt++;
    @(negedge clk);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    #1;
    total_cnt++;
    if (ctl !== C_DEF) $display("FAIL lu_bubble got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
    total_cnt++;
    if (stall_cycles !== 16'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cycles); else pass_cnt++;
    set_load_use(2'd3, 2'd0, 1'b1, 2'd3, 1'b1);
    #1;
    total_cnt++;
    if (ctl !== C_LU) $display("FAIL lu_rt_stall got=%b exp=%b", ctl, C_LU); else pass_cnt++;
    @(negedge clk);
    set_load_use(2'd1, 2'd1, 1'b0, 2'd1, 1'b0);
    #1;
    total_cnt++;
    if (ctl !== C_DEF) $display("FAIL lu_unused_src got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
    ex_mem_read = 1'b0; id_uses_rs = 1'b1;
    #1;
    total_cnt++;
    if (ctl !== C_DEF) $display("FAIL lu_not_load got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_branch;
    do_reset();
    ex_branch_taken = 1'b1; ex_branch_target = 8'h3C;
    #1;
    total_cnt++;
    if (ctl !== C_BR) $display("FAIL br_t0 got=%b exp=%b", ctl, C_BR); else pass_cnt++;
    total_cnt++;
    if (pc_target !== 8'h3C) $display("FAIL br_target got=%h exp=3c", pc_target); else pass_cnt++;
    @(negedge clk);
    ex_branch_taken = 1'b0;
    set_load_use(2'd1, 2'd1, 1'b1, 2'd0, 1'b0);
    #1;
    total_cnt++;
    if (ctl !== C_BRF) $display("FAIL br_t1 got=%b exp=%b", ctl, C_BRF); else pass_cnt++;
    @(negedge clk);
    clear_inputs();
    #1;
    total_cnt++;
    if (ctl !== C_DEF) $display("FAIL br_t2 got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
    total_cnt++;
    if (flush_events !== 16'd1) $display("FAIL br_flush_cnt got=%0d exp=1", flush_events); else pass_cnt++;
  endtask

  task automatic test_mul;
    do_reset();
    ex_alu_op = ALU_MUL;
    #1;
    total_cnt++;
    if (ctl !== C_MUL) $display("FAIL mul_t0 got=%b exp=%b", ctl, C_MUL); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (ctl !== C_MUL) $display("FAIL mul_t1 got=%b exp=%b", ctl, C_MUL); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (ctl !== C_DEF) $display("FAIL mul_t2 got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
    @(negedge clk);
    ex_alu_op = ALU_ADD;
    #1;
    total_cnt++;
    if (stall_cycles !== 16'd2) $display("FAIL mul_stall_cnt got=%0d exp=2", stall_cycles); else pass_cnt++;
    total_cnt++;
    if (ctl !== C_DEF) $display("FAIL mul_after got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
  endtask

  task automatic test_branch_vs_load_use;
    do_reset();
    set_load_use(2'd2, 2'd2, 1'b1, 2'd0, 1'b0);
    ex_branch_taken = 1'b1; ex_branch_target = 8'hA5;
    #1;
    total_cnt++;
    if (ctl !== C_BR) $display("FAIL brlu_ctl got=%b exp=%b", ctl, C_BR); else pass_cnt++;
    total_cnt++;
    if (pc_target !== 8'hA5) $display("FAIL brlu_target got=%h exp=a5", pc_target); else pass_cnt++;
    @(negedge clk);
    clear_inputs();
    #1;
    total_cnt++;
    if (stall_cycles !== 16'd0 || flush_events !== 16'd1)
      $display("FAIL brlu_cnt got=%0d/%0d exp=0/1", stall_cycles, flush_events); else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul;
    do_reset();
    ex_alu_op = ALU_MUL;
    #1;
    total_cnt++;
    if (ctl4 !== C_MUL) $display("FAIL rmul_t0 got=%b exp=%b", ctl4, C_MUL); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (ctl4 !== C_MUL) $display("FAIL rmul_t1 got=%b exp=%b", ctl4, C_MUL); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (ctl4 !== C_RESET) $display("FAIL rmul_in_rst got=%b exp=%b", ctl4, C_RESET); else pass_cnt++;
    total_cnt++;
    if (stall_cycles4 !== 16'd0) $display("FAIL rmul_rst_cnt got=%0d exp=0", stall_cycles4); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    total_cnt++;
    if (ctl4 !== C_DEF) $display("FAIL rmul_release got=%b exp=%b", ctl4, C_DEF); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (ctl4 !== C_DEF || stall_cycles4 !== 16'd0 || flush_events4 !== 16'd0)
      $display("FAIL rmul_after got=%b cnt=%0d/%0d exp=%b cnt=0/0", ctl4, stall_cycles4, flush_events4, C_DEF);
    else pass_cnt++;
  endtask

  task automatic test_saturation;
    do_reset();
    set_load_use(2'd1, 2'd1, 1'b1, 2'd0, 1'b0);
    repeat (65541) @(negedge clk);
    #1;
    total_cnt++;
    if (stall_cycles !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", stall_cycles); else pass_cnt++;
    total_cnt++;
    if (ctl !== C_LU) $display("FAIL sat_ctl got=%b exp=%b", ctl, C_LU); else pass_cnt++;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_branch_vs_load_use();
    test_reset_mid_mul();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
